// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
//
// Direct-mapped branch target buffer with 2-bit saturating direction counters
// for the fetch stage. Lookup is combinational from registered state; resolved
// branch updates from the execute stage are written on the rising clock edge.
//
// Optional feature macro: BTB_BYPASS_EN
//   When defined, a lookup whose word address equals the word address of a
//   same-cycle update sees the entry as it will be after that update.
//   When undefined, lookups read registered state only.
//
// Parameters:
//   ENTRIES               number of entries (power of two, >= 2)
//
// Ports:
//   clk                   clock, all state updates on the rising edge
//   reset                 synchronous active-high reset, clears every entry
//   lookup_pc             current fetch PC
//   predict_taken         predicted taken
//   predict_target        next-fetch PC (entry target or lookup_pc + 4)
//   btb_hit               valid entry with matching tag
//   btb_update_en         execute stage has a resolved instruction
//   btb_pc_update         PC of the resolved instruction
//   btb_target_actual     resolved target
//   btb_is_branch_or_jmp  resolved taken
// -----------------------------------------------------------------------------

package riscv_pkg;
  parameter int XLEN = 32;
endpackage

module branch_target_buffer
  import riscv_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  output logic            btb_hit,
  input  logic            btb_update_en,
  input  logic [XLEN-1:0] btb_pc_update,
  input  logic [XLEN-1:0] btb_target_actual,
  input  logic            btb_is_branch_or_jmp
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  // Saturating counter helpers.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) begin
      return 2'b11;
    end else begin
      return c + 2'b01;
    end
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) begin
      return 2'b00;
    end else begin
      return c - 2'b01;
    end
  endfunction

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][TAGW-1:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][XLEN-1:0]  target_q, target_d;
  logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;

  logic [IDX-1:0]  upd_idx_s;
  logic [TAGW-1:0] upd_tag_s;
  logic            upd_hit_s;
  logic            upd_we_s;
  logic            new_valid_s;
  logic [TAGW-1:0] new_tag_s;
  logic [XLEN-1:0] new_target_s;
  logic [1:0]      new_ctr_s;

  logic [IDX-1:0]  lk_idx_s;
  logic [TAGW-1:0] lk_tag_s;
  logic            rd_valid_s;
  logic [TAGW-1:0] rd_tag_s;
  logic [XLEN-1:0] rd_target_s;
  logic [1:0]      rd_ctr_s;

  // Update decode: the new_* signals always hold the post-update view of the
  // indexed entry (equal to the current entry when nothing is written), which
  // lets the optional bypass reuse them directly.
  always_comb begin
    upd_idx_s    = IDX'(btb_pc_update >> 2);
    upd_tag_s    = TAGW'(btb_pc_update >> (IDX + 2));
    upd_hit_s    = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
    new_valid_s  = valid_q[upd_idx_s];
    new_tag_s    = tag_q[upd_idx_s];
    new_target_s = target_q[upd_idx_s];
    new_ctr_s    = ctr_q[upd_idx_s];
    upd_we_s     = 1'b0;
    if (btb_update_en && !reset) begin
      if (btb_is_branch_or_jmp) begin
        upd_we_s     = 1'b1;
        new_target_s = btb_target_actual;
        if (upd_hit_s) begin
          new_ctr_s = ctr_inc(ctr_q[upd_idx_s]);
        end else begin
          // Allocate, replacing any different-tag occupant.
          new_valid_s = 1'b1;
          new_tag_s   = upd_tag_s;
          new_ctr_s   = 2'b10;
        end
      end else begin
        if (upd_hit_s) begin
          upd_we_s  = 1'b1;
          new_ctr_s = ctr_dec(ctr_q[upd_idx_s]);
        end else begin
          // Not-taken miss (including non-branches) leaves the table alone.
          upd_we_s = 1'b0;
        end
      end
    end else begin
      upd_we_s = 1'b0;
    end
  end

  // Next-state table: only the indexed entry can change.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_we_s) begin
      valid_d[upd_idx_s]  = new_valid_s;
      tag_d[upd_idx_s]    = new_tag_s;
      target_d[upd_idx_s] = new_target_s;
      ctr_d[upd_idx_s]    = new_ctr_s;
    end else begin
      valid_d = valid_q;
    end
  end

  // Table state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  // Lookup read, optionally forwarding a same-cycle update to the same PC.
  always_comb begin
    lk_idx_s    = IDX'(lookup_pc >> 2);
    lk_tag_s    = TAGW'(lookup_pc >> (IDX + 2));
    rd_valid_s  = valid_q[lk_idx_s];
    rd_tag_s    = tag_q[lk_idx_s];
    rd_target_s = target_q[lk_idx_s];
    rd_ctr_s    = ctr_q[lk_idx_s];
`ifdef BTB_BYPASS_EN
    if (btb_update_en && !reset && ((lookup_pc >> 2) == (btb_pc_update >> 2))) begin
      rd_valid_s  = new_valid_s;
      rd_tag_s    = new_tag_s;
      rd_target_s = new_target_s;
      rd_ctr_s    = new_ctr_s;
    end else begin
      rd_valid_s = valid_q[lk_idx_s];
    end
`else
    rd_valid_s = valid_q[lk_idx_s];
`endif
  end

  // Prediction outputs; the fall-through PC wraps naturally at XLEN bits.
  always_comb begin
    btb_hit       = rd_valid_s && (rd_tag_s == lk_tag_s);
    predict_taken = btb_hit && rd_ctr_s[1];
    if (predict_taken) begin
      predict_target = rd_target_s;
    end else begin
      predict_target = lookup_pc + PC_STEP;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

  logic        clk;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        btb_hit;
  logic        btb_update_en;
  logic [31:0] btb_pc_update;
  logic [31:0] btb_target_actual;
  logic        btb_is_branch_or_jmp;

  int passed = 0;
  int total  = 0;

  branch_target_buffer #(.ENTRIES(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .lookup_pc            (lookup_pc),
    .predict_taken        (predict_taken),
    .predict_target       (predict_target),
    .btb_hit              (btb_hit),
    .btb_update_en        (btb_update_en),
    .btb_pc_update        (btb_pc_update),
    .btb_target_actual    (btb_target_actual),
    .btb_is_branch_or_jmp (btb_is_branch_or_jmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one update for exactly one edge, then drop update_en.
  task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    btb_update_en        = 1'b1;
    btb_pc_update        = pc;
    btb_target_actual    = tgt;
    btb_is_branch_or_jmp = tk;
    tick();
    btb_update_en        = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    look(32'h0000_0100);
    total++; if (btb_hit !== 1'b0) $display("FAIL reset_hit: got %0b want 0", btb_hit); else passed++;
    total++; if (predict_taken !== 1'b0) $display("FAIL reset_taken: got %0b want 0", predict_taken); else passed++;
    total++; if (predict_target !== 32'h0000_0104) $display("FAIL reset_target: got %h want 00000104", predict_target); else passed++;
  endtask

  task automatic test_allocate();
    do_update(32'h0000_0100, 32'h0000_0200, 1'b1);
    look(32'h0000_0100);
    total++; if (btb_hit !== 1'b1) $display("FAIL alloc_hit: got %0b want 1", btb_hit); else passed++;
    total++; if (predict_taken !== 1'b1) $display("FAIL alloc_taken: got %0b want 1", predict_taken); else passed++;
    total++; if (predict_target !== 32'h0000_0200) $display("FAIL alloc_target: got %h want 00000200", predict_target); else passed++;
  endtask

  task automatic test_counter();
    // ctr 10 -> 01
    do_update(32'h0000_0100, 32'h0000_0DEA, 1'b0);
    look(32'h0000_0100);
    total++; if (btb_hit !== 1'b1) $display("FAIL dec1_hit: got %0b want 1", btb_hit); else passed++;
    total++; if (predict_taken !== 1'b0) $display("FAIL dec1_taken: got %0b want 0", predict_taken); else passed++;
    total++; if (predict_target !== 32'h0000_0104) $display("FAIL dec1_target: got %h want 00000104", predict_target); else passed++;
    // 01 -> 00 -> 00 (saturate), then one taken -> 01 still not taken
    do_update(32'h0000_0100, 32'h0000_0DEA, 1'b0);
    look(32'h0000_0100);
    total++; if (btb_hit !== 1'b1) $display("FAIL dec2_hit: got %0b want 1", btb_hit); else passed++;
    do_update(32'h0000_0100, 32'h0000_0DEA, 1'b0);
    do_update(32'h0000_0100, 32'h0000_0300, 1'b1);
    look(32'h0000_0100);
    total++; if (predict_taken !== 1'b0) $display("FAIL dec_sat_taken: got %0b want 0", predict_taken); else passed++;
    // 01 -> 10 taken, target now 0x300
    do_update(32'h0000_0100, 32'h0000_0300, 1'b1);
    look(32'h0000_0100);
    total++; if (predict_taken !== 1'b1) $display("FAIL inc2_taken: got %0b want 1", predict_taken); else passed++;
    total++; if (predict_target !== 32'h0000_0300) $display("FAIL inc2_target: got %h want 00000300", predict_target); else passed++;
    // 10 -> 11 -> 11 (saturate), then not-taken -> 10 still taken, target kept
    do_update(32'h0000_0100, 32'h0000_0300, 1'b1);
    do_update(32'h0000_0100, 32'h0000_0300, 1'b1);
    do_update(32'h0000_0100, 32'h0000_0999, 1'b0);
    look(32'h0000_0100);
    total++; if (predict_taken !== 1'b1) $display("FAIL inc_sat_taken: got %0b want 1", predict_taken); else passed++;
    total++; if (predict_target !== 32'h0000_0300) $display("FAIL nt_keeps_target: got %h want 00000300", predict_target); else passed++;
    // 10 -> 01
    do_update(32'h0000_0100, 32'h0000_0999, 1'b0);
    look(32'h0000_0100);
    total++; if (predict_taken !== 1'b0) $display("FAIL dec3_taken: got %0b want 0", predict_taken); else passed++;
    // 01 -> 10, target overwritten to 0x200
    do_update(32'h0000_0100, 32'h0000_0200, 1'b1);
    look(32'h0000_0100);
    total++; if (predict_target !== 32'h0000_0200) $display("FAIL retarget: got %h want 00000200", predict_target); else passed++;
  endtask

  task automatic test_alias();
    do_update(32'h0000_0140, 32'h0000_0777, 1'b0);
    look(32'h0000_0100);
    total++; if (btb_hit !== 1'b1) $display("FAIL alias_nt_keep_hit: got %0b want 1", btb_hit); else passed++;
    total++; if (predict_target !== 32'h0000_0200) $display("FAIL alias_nt_keep_target: got %h want 00000200", predict_target); else passed++;
    look(32'h0000_0140);
    total++; if (btb_hit !== 1'b0) $display("FAIL alias_nt_no_alloc: got %0b want 0", btb_hit); else passed++;
    total++; if (predict_target !== 32'h0000_0144) $display("FAIL alias_nt_target: got %h want 00000144", predict_target); else passed++;
    do_update(32'h0000_0140, 32'h0000_0180, 1'b1);
    look(32'h0000_0140);
    total++; if (btb_hit !== 1'b1) $display("FAIL alias_alloc_hit: got %0b want 1", btb_hit); else passed++;
    total++; if (predict_target !== 32'h0000_0180) $display("FAIL alias_alloc_target: got %h want 00000180", predict_target); else passed++;
    look(32'h0000_0100);
    total++; if (btb_hit !== 1'b0) $display("FAIL alias_evict_hit: got %0b want 0", btb_hit); else passed++;
    total++; if (predict_target !== 32'h0000_0104) $display("FAIL alias_evict_target: got %h want 00000104", predict_target); else passed++;
    // Fresh allocation restarts at 10: one not-taken makes it not-taken.
    do_update(32'h0000_0140, 32'h0000_0180, 1'b0);
    look(32'h0000_0140);
    total++; if (predict_taken !== 1'b0) $display("FAIL alias_ctr10: got %0b want 0", predict_taken); else passed++;
  endtask

  task automatic test_other_entries();
    do_update(32'h0000_0104, 32'h0000_0500, 1'b1);
    look(32'h0000_0140);
    total++; if (btb_hit !== 1'b1) $display("FAIL hold_other_hit: got %0b want 1", btb_hit); else passed++;
    look(32'h0000_0104);
    total++; if (predict_target !== 32'h0000_0500) $display("FAIL idx1_target: got %h want 00000500", predict_target); else passed++;
  endtask

  task automatic test_same_cycle();
    logic        exp_tk;
    logic [31:0] exp_tg;
`ifdef BTB_BYPASS_EN
    exp_tk = 1'b1;
    exp_tg = 32'h0000_0200;
`else
    exp_tk = 1'b0;
    exp_tg = 32'h0000_010C;
`endif
    btb_update_en        = 1'b1;
    btb_pc_update        = 32'h0000_0108;
    btb_target_actual    = 32'h0000_0200;
    btb_is_branch_or_jmp = 1'b1;
    look(32'h0000_0108);
    total++; if (predict_taken !== exp_tk) $display("FAIL same_cycle_taken: got %0b want %0b", predict_taken, exp_tk); else passed++;
    total++; if (predict_target !== exp_tg) $display("FAIL same_cycle_target: got %h want %h", predict_target, exp_tg); else passed++;
    tick();
    btb_update_en = 1'b0;
    look(32'h0000_0108);
    total++; if (predict_taken !== 1'b1) $display("FAIL next_cycle_taken: got %0b want 1", predict_taken); else passed++;
    total++; if (predict_target !== 32'h0000_0200) $display("FAIL next_cycle_target: got %h want 00000200", predict_target); else passed++;
  endtask

  task automatic test_wrap();
    look(32'hFFFF_FFFC);
    total++; if (btb_hit !== 1'b0) $display("FAIL wrap_hit: got %0b want 0", btb_hit); else passed++;
    total++; if (predict_target !== 32'h0000_0000) $display("FAIL wrap_target: got %h want 00000000", predict_target); else passed++;
  endtask

  task automatic test_reset_with_update();
    reset                = 1'b1;
    btb_update_en        = 1'b1;
    btb_pc_update        = 32'h0000_010C;
    btb_target_actual    = 32'h0000_0700;
    btb_is_branch_or_jmp = 1'b1;
    look(32'h0000_0140);
    total++; if (btb_hit !== 1'b1) $display("FAIL pre_reset_state_hit: got %0b want 1", btb_hit); else passed++;
    tick();
    reset         = 1'b0;
    btb_update_en = 1'b0;
    look(32'h0000_010C);
    total++; if (btb_hit !== 1'b0) $display("FAIL reset_drop_update: got %0b want 0", btb_hit); else passed++;
    total++; if (predict_target !== 32'h0000_0110) $display("FAIL reset_drop_target: got %h want 00000110", predict_target); else passed++;
    look(32'h0000_0140);
    total++; if (btb_hit !== 1'b0) $display("FAIL reset_clear_140: got %0b want 0", btb_hit); else passed++;
    look(32'h0000_0108);
    total++; if (btb_hit !== 1'b0) $display("FAIL reset_clear_108: got %0b want 0", btb_hit); else passed++;
    look(32'h0000_0104);
    total++; if (predict_taken !== 1'b0) $display("FAIL reset_clear_104: got %0b want 0", predict_taken); else passed++;
  endtask

  initial begin
    reset                = 1'b1;
    lookup_pc            = 32'h0000_0000;
    btb_update_en        = 1'b0;
    btb_pc_update        = 32'h0000_0000;
    btb_target_actual    = 32'h0000_0000;
    btb_is_branch_or_jmp = 1'b0;
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_other_entries();
    test_same_cycle();
    test_wrap();
    test_reset_with_update();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
